// File: rtl/canv_disp_unpack.sv
// Canvas display pixel unpacker: issues VRAM reads with same-word suppression,
// extracts the packed colour index for each pixel and presents it to the CLUT.
module canv_disp_unpack #(
   parameter int WORD     = 32,
   parameter int ADDRW    = 14,
   parameter int PIX_IDW  = $clog2(WORD),
   parameter int SHIFTW   = 3,
   parameter int CIDXW    = 8,
   parameter int VRAM_LAT = 1
) (
   input  logic               clk_pix,
   input  logic               rst_pix,
   input  logic               frame_start,
   input  logic               rd_en,
   input  logic [ADDRW-1:0]   addr,
   input  logic [PIX_IDW-1:0] pix_id,
   input  logic [SHIFTW-1:0]  addr_shift,
   input  logic [CIDXW-1:0]   bg_idx,
   output logic [ADDRW-1:0]   vram_addr,
   output logic               vram_re,
   input  logic [WORD-1:0]    vram_data,
   output logic [CIDXW-1:0]   clut_idx,
   output logic               canv_px
);

   localparam int LOG2W = $clog2(WORD);

   logic                           vramRe_q, vramRe_d;
   logic [ADDRW-1:0]               vramAddr_q, vramAddr_d;
   logic                           lastValid_q, lastValid_d;
   logic [VRAM_LAT:0]              dlyRd_q, dlyRd_d;
   logic [VRAM_LAT:0]              dlyIss_q, dlyIss_d;
   logic [VRAM_LAT:0][PIX_IDW-1:0] dlyPid_q, dlyPid_d;
   logic [VRAM_LAT:0][SHIFTW-1:0]  dlyShift_q, dlyShift_d;
   logic [WORD-1:0]                wordHold_q, wordHold_d;
   logic [CIDXW-1:0]               clutIdx_q, clutIdx_d;
   logic                           canvPx_q, canvPx_d;

   logic                           issue;
   logic                           tailRd;
   logic                           tailIss;
   logic [PIX_IDW-1:0]             tailPid;
   logic [SHIFTW-1:0]              tailShift;
   logic [WORD-1:0]                srcWord;
   int                             shiftAmt;
   logic [PIX_IDW-1:0]             pidMasked;
   logic [PIX_IDW-1:0]             bitOff;
   logic [WORD-1:0]                bppMask;
   logic [WORD-1:0]                pixBits;

   // The held VRAM address doubles as the last-requested address, since both
   // change only when a read is issued.
   always_comb begin
      issue       = rd_en && (frame_start || !lastValid_q || (addr != vramAddr_q));
      vramRe_d    = issue;
      vramAddr_d  = issue ? addr : vramAddr_q;
      lastValid_d = issue ? 1'b1 : (frame_start ? 1'b0 : lastValid_q);
      dlyRd_d     = {dlyRd_q[VRAM_LAT-1:0], rd_en};
      dlyIss_d    = {dlyIss_q[VRAM_LAT-1:0], issue};
      dlyPid_d    = {dlyPid_q[VRAM_LAT-1:0], pix_id};
      dlyShift_d  = {dlyShift_q[VRAM_LAT-1:0], addr_shift};
   end

   always_comb begin
      tailRd    = dlyRd_q[VRAM_LAT];
      tailIss   = dlyIss_q[VRAM_LAT];
      tailPid   = dlyPid_q[VRAM_LAT];
      tailShift = dlyShift_q[VRAM_LAT];
      srcWord   = tailIss ? vram_data : wordHold_q;
      shiftAmt  = (int'(tailShift) > LOG2W) ? LOG2W : int'(tailShift);
      pidMasked = tailPid & PIX_IDW'((1 << shiftAmt) - 1);
      // pid * bpp, where bpp = 2^(LOG2W - s); a full-word shift yields an all-ones mask
      bitOff    = pidMasked << (LOG2W - shiftAmt);
      bppMask   = ~({WORD{1'b1}} << (WORD >> shiftAmt));
      pixBits   = (srcWord >> bitOff) & bppMask;
      wordHold_d = srcWord;
      clutIdx_d  = tailRd ? CIDXW'(pixBits) : bg_idx;
      canvPx_d   = tailRd;
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         vramRe_q    <= 1'b0;
         vramAddr_q  <= '0;
         lastValid_q <= 1'b0;
         dlyRd_q     <= '0;
         dlyIss_q    <= '0;
         dlyPid_q    <= '0;
         dlyShift_q  <= '0;
         wordHold_q  <= '0;
         clutIdx_q   <= '0;
         canvPx_q    <= 1'b0;
      end else begin
         vramRe_q    <= vramRe_d;
         vramAddr_q  <= vramAddr_d;
         lastValid_q <= lastValid_d;
         dlyRd_q     <= dlyRd_d;
         dlyIss_q    <= dlyIss_d;
         dlyPid_q    <= dlyPid_d;
         dlyShift_q  <= dlyShift_d;
         wordHold_q  <= wordHold_d;
         clutIdx_q   <= clutIdx_d;
         canvPx_q    <= canvPx_d;
      end
   end

   assign vram_re   = vramRe_q;
   assign vram_addr = vramAddr_q;
   assign clut_idx  = clutIdx_q;
   assign canv_px   = canvPx_q;

endmodule

// File: tb/tb_canv_disp_unpack.sv
// Bench for canv_disp_unpack: two instances (VRAM_LAT 1 and 3) share stimulus,
// each fed by its own VRAM model and checked against a per-cycle expectation table.
module tb_canv_disp_unpack;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int LA    = LAT_A + 2;
   localparam int LB    = LAT_B + 2;
   localparam int NCYC  = 1024;

   logic        clk_pix = 1'b0;
   logic        rst_pix;
   logic        frame_start;
   logic        rd_en;
   logic [13:0] addr;
   logic [4:0]  pix_id;
   logic [2:0]  addr_shift;
   logic [7:0]  bg_idx;

   logic [13:0] vramAddrA, vramAddrB;
   logic        vramReA, vramReB;
   logic [31:0] vramDataA, vramDataB;
   logic [7:0]  clutIdxA, clutIdxB;
   logic        canvPxA, canvPxB;

   always #5 clk_pix = ~clk_pix;

   canv_disp_unpack #(.VRAM_LAT(LAT_A)) dutA (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start), .rd_en(rd_en),
      .addr(addr), .pix_id(pix_id), .addr_shift(addr_shift), .bg_idx(bg_idx),
      .vram_addr(vramAddrA), .vram_re(vramReA), .vram_data(vramDataA),
      .clut_idx(clutIdxA), .canv_px(canvPxA)
   );

   canv_disp_unpack #(.VRAM_LAT(LAT_B)) dutB (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start), .rd_en(rd_en),
      .addr(addr), .pix_id(pix_id), .addr_shift(addr_shift), .bg_idx(bg_idx),
      .vram_addr(vramAddrB), .vram_re(vramReB), .vram_data(vramDataB),
      .clut_idx(clutIdxB), .canv_px(canvPxB)
   );

   // VRAM models return garbage whenever no read was issued, so a reuse that
   // wrongly takes vram_data instead of the held word shows up.
   logic [31:0] mem [0:63];
   logic [31:0] pipeA;
   logic [31:0] pipeB [1:3];
   assign vramDataA = pipeA;
   assign vramDataB = pipeB[3];

   always @(posedge clk_pix) begin
      pipeA    <= vramReA ? mem[vramAddrA[5:0]] : 32'hDEAD_BEEF;
      pipeB[1] <= vramReB ? mem[vramAddrB[5:0]] : 32'hDEAD_BEEF;
      pipeB[2] <= pipeB[1];
      pipeB[3] <= pipeB[2];
   end

   int cyc = 0;
   always @(posedge clk_pix) cyc <= cyc + 1;

   int checkCount = 0;
   int passCount  = 0;
   int reCntA = 0;
   int reCntB = 0;

   logic       expValA [0:NCYC-1];
   logic [7:0] expIdxA [0:NCYC-1];
   logic       expPxA  [0:NCYC-1];
   logic       expValB [0:NCYC-1];
   logic [7:0] expIdxB [0:NCYC-1];
   logic       expPxB  [0:NCYC-1];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Outputs are compared mid-cycle against whatever the table holds for this cycle.
   always @(negedge clk_pix) begin
      if (cyc < NCYC) begin
         if (expValA[cyc]) begin
            checkOutput($sformatf("A.clut_idx@%0d", cyc), 32'(clutIdxA), 32'(expIdxA[cyc]));
            checkOutput($sformatf("A.canv_px@%0d", cyc), 32'(canvPxA), 32'(expPxA[cyc]));
         end
         if (expValB[cyc]) begin
            checkOutput($sformatf("B.clut_idx@%0d", cyc), 32'(clutIdxB), 32'(expIdxB[cyc]));
            checkOutput($sformatf("B.canv_px@%0d", cyc), 32'(canvPxB), 32'(expPxB[cyc]));
         end
      end
      if (vramReA === 1'b1) reCntA++;
      if (vramReB === 1'b1) reCntB++;
   end

   function automatic logic [7:0] refIdx(input logic [31:0] w, input int pid, input int sh);
      int s;
      int bpp;
      int p;
      logic [7:0] r;
      s   = (sh > 5) ? 5 : sh;
      bpp = 32 >> s;
      p   = pid % (1 << s);
      r   = 8'h00;
      for (int b = 0; b < bpp && b < 8; b++) r[b] = w[p * bpp + b];
      return r;
   endfunction

   task automatic applyStimulus(input logic re, input logic [13:0] a, input logic [4:0] pid,
                                input logic [2:0] sh, input logic fs, input logic [7:0] expIdx);
      rd_en       = re;
      addr        = a;
      pix_id      = pid;
      addr_shift  = sh;
      frame_start = fs;
      expValA[cyc + LA] = 1'b1;
      expIdxA[cyc + LA] = re ? expIdx : bg_idx;
      expPxA[cyc + LA]  = re;
      expValB[cyc + LB] = 1'b1;
      expIdxB[cyc + LB] = re ? expIdx : bg_idx;
      expPxB[cyc + LB]  = re;
      @(posedge clk_pix);
      #1;
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 14'h0, 5'd0, 3'd2, 1'b0, 8'h00);
   endtask

   // In-flight pixels are dropped: zeros on the reset cycle, then background only.
   task automatic doReset();
      rst_pix = 1'b1;
      rd_en   = 1'b0;
      for (int c = cyc + 2; c <= cyc + LA; c++) begin
         expValA[c] = 1'b1; expIdxA[c] = bg_idx; expPxA[c] = 1'b0;
      end
      for (int c = cyc + 2; c <= cyc + LB; c++) begin
         expValB[c] = 1'b1; expIdxB[c] = bg_idx; expPxB[c] = 1'b0;
      end
      expValA[cyc + 1] = 1'b1; expIdxA[cyc + 1] = 8'h00; expPxA[cyc + 1] = 1'b0;
      expValB[cyc + 1] = 1'b1; expIdxB[cyc + 1] = 8'h00; expPxB[cyc + 1] = 1'b0;
      @(posedge clk_pix);
      #1;
      checkOutput("A.vram_re reset", 32'(vramReA), 32'd0);
      checkOutput("A.vram_addr reset", 32'(vramAddrA), 32'd0);
      checkOutput("B.vram_re reset", 32'(vramReB), 32'd0);
      checkOutput("B.vram_addr reset", 32'(vramAddrB), 32'd0);
      rst_pix = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rA;
      int rB;
      for (int i = 0; i < NCYC; i++) begin
         expValA[i] = 1'b0; expIdxA[i] = 8'h00; expPxA[i] = 1'b0;
         expValB[i] = 1'b0; expIdxB[i] = 8'h00; expPxB[i] = 1'b0;
      end
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[6'h10] = 32'h4433_2211;
      mem[6'h11] = 32'h0000_0005;
      mem[6'h12] = 32'h8765_4321;
      mem[6'h13] = 32'hAABB_CCDD;
      mem[6'h20] = 32'h5A00_00A1;
      mem[6'h21] = 32'h0000_00B2;
      for (int i = 0; i < 16; i++) mem[6'h30 + i] = 32'(32'h9E37_79B9 * (i + 1));

      rst_pix = 1'b1; frame_start = 1'b0; rd_en = 1'b0;
      addr = 14'h0; pix_id = 5'd0; addr_shift = 3'd2; bg_idx = 8'h05;

      doReset();
      rA = reCntA; rB = reCntB;
      idle(4);
      checkOutput("A.idle reads", 32'(reCntA - rA), 32'd0);
      checkOutput("B.idle reads", 32'(reCntB - rB), 32'd0);

      // 8bpp, four pixels from one word
      rA = reCntA; rB = reCntB;
      applyStimulus(1'b1, 14'h10, 5'd0, 3'd2, 1'b0, 8'h11);
      applyStimulus(1'b1, 14'h10, 5'd1, 3'd2, 1'b0, 8'h22);
      applyStimulus(1'b1, 14'h10, 5'd2, 3'd2, 1'b0, 8'h33);
      applyStimulus(1'b1, 14'h10, 5'd3, 3'd2, 1'b0, 8'h44);
      idle(6);
      checkOutput("A.8bpp reads", 32'(reCntA - rA), 32'd1);
      checkOutput("B.8bpp reads", 32'(reCntB - rB), 32'd1);
      checkOutput("A.8bpp vram_addr", 32'(vramAddrA), 32'h10);
      checkOutput("B.8bpp vram_addr", 32'(vramAddrB), 32'h10);

      // 1bpp and 4bpp
      applyStimulus(1'b1, 14'h11, 5'd0, 3'd5, 1'b0, 8'h01);
      applyStimulus(1'b1, 14'h11, 5'd1, 3'd5, 1'b0, 8'h00);
      applyStimulus(1'b1, 14'h11, 5'd2, 3'd5, 1'b0, 8'h01);
      applyStimulus(1'b1, 14'h11, 5'd3, 3'd5, 1'b0, 8'h00);
      applyStimulus(1'b1, 14'h12, 5'd7, 3'd3, 1'b0, 8'h08);

      // 32bpp truncation, shift clamp, pix_id masking; shift changes on a reused word
      applyStimulus(1'b1, 14'h13, 5'd0,  3'd0, 1'b0, 8'hDD);
      applyStimulus(1'b1, 14'h13, 5'd2,  3'd7, 1'b0, 8'h01);
      applyStimulus(1'b1, 14'h13, 5'd1,  3'd7, 1'b0, 8'h00);
      applyStimulus(1'b1, 14'h13, 5'd31, 3'd7, 1'b0, 8'h01);
      applyStimulus(1'b1, 14'h13, 5'd5,  3'd2, 1'b0, 8'hCC);
      idle(6);

      // Alternating addresses, a suppressed repeat, then a forced re-read
      rA = reCntA; rB = reCntB;
      applyStimulus(1'b1, 14'h20, 5'd0, 3'd2, 1'b0, 8'hA1);
      applyStimulus(1'b1, 14'h21, 5'd0, 3'd2, 1'b0, 8'hB2);
      applyStimulus(1'b1, 14'h20, 5'd0, 3'd2, 1'b0, 8'hA1);
      applyStimulus(1'b1, 14'h20, 5'd3, 3'd2, 1'b0, 8'h5A);
      applyStimulus(1'b1, 14'h20, 5'd0, 3'd2, 1'b1, 8'hA1);
      idle(6);
      checkOutput("A.alt reads", 32'(reCntA - rA), 32'd4);
      checkOutput("B.alt reads", 32'(reCntB - rB), 32'd4);

      // frame_start on an idle cycle still invalidates the cached word
      rA = reCntA; rB = reCntB;
      applyStimulus(1'b0, 14'h20, 5'd0, 3'd2, 1'b1, 8'h00);
      applyStimulus(1'b1, 14'h20, 5'd3, 3'd2, 1'b0, 8'h5A);
      idle(6);
      checkOutput("A.idle fs reads", 32'(reCntA - rA), 32'd1);
      checkOutput("B.idle fs reads", 32'(reCntB - rB), 32'd1);

      // 2bpp stream of 16 distinct words
      rA = reCntA; rB = reCntB;
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 14'(14'h30 + i), 5'((i * 5) % 16), 3'd4, 1'b0,
                       refIdx(mem[6'h30 + i], (i * 5) % 16, 4));
      idle(6);
      checkOutput("A.stream reads", 32'(reCntA - rA), 32'd16);
      checkOutput("B.stream reads", 32'(reCntB - rB), 32'd16);

      // Reset mid-run, then the same address must be read again
      rA = reCntA; rB = reCntB;
      applyStimulus(1'b1, 14'h10, 5'd0, 3'd2, 1'b0, 8'h11);
      applyStimulus(1'b1, 14'h10, 5'd1, 3'd2, 1'b0, 8'h22);
      doReset();
      idle(2);
      applyStimulus(1'b1, 14'h10, 5'd2, 3'd2, 1'b0, 8'h33);
      idle(8);
      checkOutput("A.reset reads", 32'(reCntA - rA), 32'd2);
      checkOutput("B.reset reads", 32'(reCntB - rB), 32'd2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
